// File: rtl/yd_wb_arb.sv
// ---------------------------------------------------------------------------
// yd_wb_arb -- write-back arbiter for a two-write-port register file.
//
// Three requesters offer (address, data) writes with a valid/ready handshake.
// Each cycle up to two eligible requests are granted and appear on the two
// register-file write ports one cycle later.
//
// Eligibility:
//   - address 4'h0 : always accepted and discarded (no port, no pointer move)
//   - address 4'hF : PC write, eligible only while jpc is high
//   - any other    : eligible whenever valid
// Two grants in the same cycle never target the same address.
//
// Configuration macro:
//   YD_WBA_RR_EN  defined   -> rotating priority starting at ptr; after a
//                              grant ptr moves one past the last port-granted
//                              requester.
//                 undefined -> fixed priority 0 > 1 > 2 (ptr held at 0).
//
// Ports:
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   jpc        in   1   pipeline-bubble flag, permits writes to address 4'hF
//   req_vld    in   3   per-requester request valid (bit i = requester i)
//   req_addr   in  12   per-requester address, bits [4i+3:4i]
//   req_data   in  48   per-requester data, bits [16i+15:16i]
//   req_rdy    out  3   per-requester accept (combinational)
//   waddr0/din0/we0  out 4/16/1  write port 0 (registered)
//   waddr1/din1/we1  out 4/16/1  write port 1 (registered)
//   stall_cnt  out 16   saturating count of cycles with a valid, unaccepted
//                       request
// ---------------------------------------------------------------------------
module yd_wb_arb (
    input  logic        clk,
    input  logic        rst,
    input  logic        jpc,
    input  logic [2:0]  req_vld,
    input  logic [11:0] req_addr,
    input  logic [47:0] req_data,
    output logic [2:0]  req_rdy,
    output logic [3:0]  waddr0,
    output logic [15:0] din0,
    output logic        we0,
    output logic [3:0]  waddr1,
    output logic [15:0] din1,
    output logic        we1,
    output logic [15:0] stall_cnt
);

    localparam logic [3:0]  ADDR_NULL = 4'h0;
    localparam logic [3:0]  ADDR_PC   = 4'hF;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // Reduce a value in 0..4 modulo 3.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    logic [1:0]  ptr;
    logic [1:0]  ptr_next;
    logic [2:0]  zero_addr;
    logic [2:0]  elig;
    logic [2:0]  grant;
    logic [1:0]  idx;
    logic        g0_vld;
    logic [1:0]  g0_idx;
    logic        g1_vld;
    logic [1:0]  g1_idx;
    logic [3:0]  g0_addr;
    logic [15:0] g0_data;
    logic [3:0]  g1_addr;
    logic [15:0] g1_data;
    logic        stall_event;

    // -----------------------------------------------------------------------
    // Per-requester classification.
    // -----------------------------------------------------------------------
    // NOTE: every signal driven from always_comb gets a default at the top of
    // the block; a path that leaves one unassigned would infer a latch.
    always_comb begin
        zero_addr = '0;
        elig      = '0;
        for (int i = 0; i < 3; i++) begin
            zero_addr[i] = (req_addr[4*i +: 4] == ADDR_NULL);
            elig[i]      = req_vld[i] && !zero_addr[i] &&
                           ((req_addr[4*i +: 4] != ADDR_PC) || jpc);
        end
    end

    // -----------------------------------------------------------------------
    // Grant selection: walk ptr, ptr+1, ptr+2. The first eligible request
    // takes port 0; the next eligible one whose address differs from the
    // port-0 winner takes port 1. Nothing is granted during reset.
    // -----------------------------------------------------------------------
    always_comb begin
        g0_vld = 1'b0;
        g0_idx = 2'd0;
        g1_vld = 1'b0;
        g1_idx = 2'd0;
        grant  = '0;
        idx    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            idx = wrap3({1'b0, ptr} + 3'(k));
            if (elig[idx] && !rst) begin
                if (!g0_vld) begin
                    g0_vld     = 1'b1;
                    g0_idx     = idx;
                    grant[idx] = 1'b1;
                end else if (!g1_vld &&
                             (req_addr[{idx, 2'b00} +: 4] !=
                              req_addr[{g0_idx, 2'b00} +: 4])) begin
                    g1_vld     = 1'b1;
                    g1_idx     = idx;
                    grant[idx] = 1'b1;
                end
            end
        end
    end

    assign g0_addr = req_addr[{g0_idx, 2'b00} +: 4];
    assign g0_data = req_data[{g0_idx, 4'b0000} +: 16];
    assign g1_addr = req_addr[{g1_idx, 2'b00} +: 4];
    assign g1_data = req_data[{g1_idx, 4'b0000} +: 16];

    // Null-address requests are swallowed every cycle outside reset.
    assign req_rdy     = rst ? 3'b000 : (grant | zero_addr);
    assign stall_event = |(req_vld & ~req_rdy);

    // -----------------------------------------------------------------------
    // Priority pointer. Discarded null-address transfers never move it.
    // -----------------------------------------------------------------------
    always_comb begin
        ptr_next = ptr;
`ifdef YD_WBA_RR_EN
        if (g1_vld) begin
            ptr_next = wrap3({1'b0, g1_idx} + 3'd1);
        end else if (g0_vld) begin
            ptr_next = wrap3({1'b0, g0_idx} + 3'd1);
        end
`else
        ptr_next = 2'd0;
`endif
    end

    // -----------------------------------------------------------------------
    // Registered state. Ports without a grant drop we but keep addr/data.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= 2'd0;
            we0       <= 1'b0;
            waddr0    <= 4'h0;
            din0      <= 16'h0;
            we1       <= 1'b0;
            waddr1    <= 4'h0;
            din1      <= 16'h0;
            stall_cnt <= 16'h0;
        end else begin
            ptr <= ptr_next;
            we0 <= g0_vld;
            we1 <= g1_vld;
            if (g0_vld) begin
                waddr0 <= g0_addr;
                din0   <= g0_data;
            end
            if (g1_vld) begin
                waddr1 <= g1_addr;
                din1   <= g1_data;
            end
            if (stall_event && (stall_cnt != STALL_MAX)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/yd_wb_arb.md
YD_WB_ARB -- requirements
Module: yd_wb_arb

Interface
REQ-001 Parameter: none; all widths fixed (address 4 b, data 16 b, 3 requesters).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 jpc  input  1  pipeline-bubble flag; high permits writes to PC (address 4'hF).
REQ-005 req_vld  input  3  per-requester write request valid; bit i = requester i.
REQ-006 req_addr  input  12  per-requester destination address; bits [4i+3:4i].
REQ-007 req_data  input  48  per-requester write data; bits [16i+15:16i].
REQ-008 req_rdy  output  3  per-requester accept, combinational from current inputs and state.
REQ-009 waddr0/din0/we0  output  4/16/1  register-file write port 0, registered.
REQ-010 waddr1/din1/we1  output  4/16/1  register-file write port 1, registered.
REQ-011 stall_cnt  output  16  saturating count of cycles with any valid requester not accepted.

Function
REQ-012 Transfer of requester i occurs in a cycle where req_vld[i] and req_rdy[i] are both high; requester holds vld/addr/data stable until transfer.
REQ-013 Address 4'h0 requests are always ready, are discarded, use no port and do not move the priority pointer.
REQ-014 Address 4'hF requests are never ready while jpc is low; they are eligible only when jpc is high.
REQ-015 Priority order is ptr, ptr+1, ptr+2 (mod 3); at most two eligible nonzero requests are granted per cycle.
REQ-016 First granted request in priority order drives port 0; second granted drives port 1.
REQ-017 A request whose address equals an already granted request's address in the same cycle is not granted (no same-address dual write).
REQ-018 Granted request appears on its port one cycle after transfer: waddrN/dinN = captured addr/data, weN = 1.
REQ-019 Port with no grant in a cycle: weN = 0 next cycle, waddrN/dinN hold previous values.
REQ-020 Pointer update: if any port grant occurred, ptr <= (index of last port-granted requester + 1) mod 3; otherwise ptr holds.
REQ-021 stall_cnt increments by 1 in each cycle with (req_vld & ~req_rdy) nonzero; saturates at 16'hFFFF, never wraps.
REQ-022 Ungranted requests remain pending with no starvation: under REQ-020, any continuously valid eligible requester is granted within 3 cycles.
REQ-023 jpc falling while an address-4'hF request is pending: request is not granted that cycle; it waits for jpc high.

Reset
REQ-024 rst high at posedge clk: we0 = we1 = 0, waddr0 = waddr1 = 4'h0, din0 = din1 = 16'h0, ptr = 0, stall_cnt = 0.
REQ-025 While rst is high, req_rdy = 3'b000; no transfer occurs; a pending request is accepted only after rst deasserts.
REQ-026 Reset mid-operation discards any write captured in that cycle (the write never reaches a port).

Configuration
REQ-027 Macro YD_WBA_RR_EN defined: rotating priority per REQ-015/REQ-020.
REQ-028 YD_WBA_RR_EN undefined: fixed priority 0 > 1 > 2, ptr held at 0; all other rules unchanged.

Verification
REQ-029 Reset, then req_vld=3'b111, addrs 2/3/4, data 16'h1111/2222/3333 -> cycle 1: port0 = (2,1111), port1 = (3,2222), req_rdy = 3'b011; cycle 2: port0 = (4,3333), we1 = 0.
REQ-030 Req0 and req1 both addr 5, data A5A5/5A5A, ptr=0 -> port0 = (5,A5A5), we1 = 0, req1 granted next cycle on port0.
REQ-031 Req2 addr 4'hF with jpc=0 for 4 cycles, then jpc=1 -> req_rdy[2]=0 for 4 cycles, stall_cnt=4, then port0 = (F,data), we0 = 1 one cycle later.
REQ-032 Req1 addr 0 alone -> req_rdy[1]=1 same cycle, we0 = we1 = 0 next cycle, ptr unchanged.
REQ-033 All three continuously valid, distinct addrs 6/7/8, YD_WBA_RR_EN defined -> grants rotate (0,1),(2,0),(1,2) over three cycles; undefined -> (0,1),(0,1) with req2 starved.
REQ-034 Hold req0 = addr F, jpc=0 for 70000 cycles -> stall_cnt = 16'hFFFF and stays; rst mid-run -> stall_cnt = 0, we0 = we1 = 0 next cycle.
